dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_pkg.sv | 32 +++
 rtl/dmem_ctrl_lane.sv | 40 ++++
 rtl/dmem_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory stage: access types, FSM states,
// and lane/alignment helpers.
package dmem_ctrl_pkg;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  function automatic logic is_half(logic [2:0] t);
    return (t == dm_halfword) || (t == dm_halfword_unsigned);
  endfunction

  function automatic logic is_byte(logic [2:0] t);
    return (t == dm_byte) || (t == dm_byte_unsigned);
  endfunction

  // Codes 101..111 fall through to word rules.
  function automatic logic dm_aligned(logic [2:0] t, logic [1:0] off);
    if (is_byte(t)) return 1'b1;
    if (is_half(t)) return !off[0];
    return off == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// Lane formatter: store side places data on lanes with byte enables,
// load side extracts and extends the addressed byte/half.
module dm_lane
  import dmem_ctrl_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [2:0]  typ,
  input  logic [1:0]  off,
  input  logic [31:0] din,
  output logic [3:0]  be,
  output logic [31:0] dout
);

  logic [7:0]  bv;
  logic [15:0] hv;
  logic        sx;

  always_comb begin
    bv   = 8'(din >> {off, 3'b000});
    hv   = off[1] ? din[31:16] : din[15:0];
    sx   = (typ == dm_byte) || (typ == dm_halfword);
    be   = 4'hF;
    dout = din;
    unique case (1'b1)
      is_byte(typ): begin
        be   = 4'b0001 << off;
        dout = LOAD ? {{24{sx & bv[7]}}, bv}
                    : {4{din[7:0]}};
      end
      is_half(typ): begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        dout = LOAD ? {{16{sx & hv[15]}}, hv}
                    : {2{din[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: word array, lane merge, load extension,
// misalignment rejection and a wait-state FSM driving busy.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        misalign,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    typ_q, typ_d;
  logic          wr_q, wr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wword_q, wword_d;
  logic [31:0]   rd_word_q, rd_word_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic          req, ok, acc, we;
  logic [3:0]    st_be;
  logic [31:0]   st_word;
  logic [3:0]    ld_be_unused;
  logic          addr_unused;

  assign addr_unused = ^addr[31:AW+2];
  assign err = err_q;

  dm_lane #(.LOAD(1'b0)) u_st (
    .typ  (dm_type),
    .off  (addr[1:0]),
    .din  (wdata),
    .be   (st_be),
    .dout (st_word)
  );

  dm_lane #(.LOAD(1'b1)) u_ld (
    .typ  (typ_q),
    .off  (off_q),
    .din  (rd_word_q),
    .be   (ld_be_unused),
    .dout (rdata)
  );

  always_comb begin
    req      = mem_r | mem_w;
    ok       = dm_aligned(dm_type, addr[1:0]);
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    off_d    = off_q;
    typ_d    = typ_q;
    wr_d     = wr_q;
    be_d     = be_q;
    wword_d  = wword_q;
    err_d    = err_q;
    acc      = 1'b0;
    busy     = 1'b0;
    misalign = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req && ok) begin
          busy    = 1'b1;
          idx_d   = addr[AW+1:2];
          off_d   = addr[1:0];
          typ_d   = dm_type;
          wr_d    = mem_w;
          be_d    = st_be;
          wword_d = st_word;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            acc     = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else if (req) begin
          misalign = 1'b1;
          err_d    = 1'b1;
        end
      end
      S_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Access uses the _d view so a zero-wait accept writes/reads live data.
    we        = acc & wr_d & rst;
    rd_word_d = (acc && !wr_d) ? mem[idx_d] : rd_word_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      typ_q     <= '0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      wword_q   <= '0;
      rd_word_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      typ_q     <= typ_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      wword_q   <= wword_d;
      rd_word_q <= rd_word_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) mem[idx_d][8*i +: 8] <= wword_d[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one-wait and zero-wait instances
// sharing request buses, selected by `fast`.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fast = 1'b0;
  logic        mem_r = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  dm_type = '0;

  logic [31:0] rdata1, rdata0;
  logic        busy1, busy0, mis1, mis0, err1, err0;
  logic        r1, w1, r0, w0;
  logic        busy_s;
  logic [31:0] rdata_s;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];

  assign r1 = mem_r & !fast;
  assign w1 = mem_w & !fast;
  assign r0 = mem_r & fast;
  assign w0 = mem_w & fast;
  assign busy_s  = fast ? busy0 : busy1;
  assign rdata_s = fast ? rdata0 : rdata1;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_slow (
    .clk(clk), .rst(rst), .mem_r(r1), .mem_w(w1),
    .addr(addr), .wdata(wdata), .dm_type(dm_type),
    .rdata(rdata1), .busy(busy1), .misalign(mis1), .err(err1)
  );

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .rst(rst), .mem_r(r0), .mem_w(w0),
    .addr(addr), .wdata(wdata), .dm_type(dm_type),
    .rdata(rdata0), .busy(busy0), .misalign(mis0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic acc(input string tag, input bit f, input bit r,
                     input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] t);
    int nb;
    logic [31:0] e;
    nb = 0;
    @(negedge clk);
    fast = f; addr = a; wdata = d; dm_type = t;
    mem_r = r; mem_w = w;
    #1;
    while (busy_s && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check({tag, "_stall"}, 32'(nb), f ? 32'd1 : 32'd2);
    if (r && !w && sb.size() > 0) begin
      e = sb.pop_front();
      check(tag, rdata_s, e);
    end
    mem_r = 1'b0;
    mem_w = 1'b0;
  endtask

  task automatic ld(input string tag, input bit f, input logic [31:0] a,
                    input logic [2:0] t, input logic [31:0] exp);
    sb.push_back(exp);
    acc(tag, f, 1'b1, 1'b0, a, 32'h0, t);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_rdata", rdata1, 32'h0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_mis", 32'(mis1), 32'd0);
    rst = 1'b1;

    acc("st_w", 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b000);
    ld("ld_w", 1'b0, 32'h10, 3'b000, 32'hDEADBEEF);

    acc("st_z", 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b000);
    acc("st_b", 1'b0, 1'b0, 1'b1, 32'h13, 32'h80, 3'b011);
    ld("ld_b", 1'b0, 32'h13, 3'b011, 32'hFFFFFF80);
    ld("ld_bu", 1'b0, 32'h13, 3'b100, 32'h00000080);
    ld("ld_bw", 1'b0, 32'h10, 3'b000, 32'h80000000);

    acc("st_w2", 1'b0, 1'b0, 1'b1, 32'h20, 32'h11223344, 3'b000);
    acc("st_h", 1'b0, 1'b0, 1'b1, 32'h22, 32'h8001, 3'b001);
    ld("ld_h", 1'b0, 32'h22, 3'b001, 32'hFFFF8001);
    ld("ld_hu", 1'b0, 32'h22, 3'b010, 32'h00008001);
    ld("ld_hw", 1'b0, 32'h20, 3'b000, 32'h80013344);
    ld("ld_t7", 1'b0, 32'h20, 3'b111, 32'h80013344);
    ld("ld_bu1", 1'b0, 32'h21, 3'b100, 32'h00000033);

    acc("st_old", 1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 3'b000);
    @(negedge clk);
    fast = 1'b0; addr = 32'h40; wdata = 32'h12345678;
    dm_type = 3'b000; mem_w = 1'b1;
    #1;
    check("mid_acc", 32'(busy1), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    mem_w = 1'b0;
    #1;
    check("mid_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    check("mid_rdata", rdata1, 32'h0);
    rst = 1'b1;
    ld("ld_old", 1'b0, 32'h40, 3'b000, 32'hCAFEF00D);

    @(negedge clk);
    fast = 1'b0; addr = 32'h06; dm_type = 3'b000; mem_r = 1'b1;
    #1;
    check("mis_flag", 32'(mis1), 32'd1);
    check("mis_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    check("mis_err", 32'(err1), 32'd1);
    check("mis_idle", 32'(busy1), 32'd0);
    mem_r = 1'b0; mem_w = 1'b1; addr = 32'h21;
    wdata = 32'hFFFF; dm_type = 3'b001;
    #1;
    check("mis_hst", 32'(mis1), 32'd1);
    @(negedge clk);
    mem_w = 1'b0;
    #1;
    check("mis_clr", 32'(mis1), 32'd0);
    ld("mis_arr", 1'b0, 32'h20, 3'b000, 32'h80013344);
    check("err_stk", 32'(err1), 32'd1);

    acc("both", 1'b1, 1'b1, 1'b1, 32'h1008, 32'hA5A55A5A, 3'b000);
    ld("alias", 1'b1, 32'h8, 3'b000, 32'hA5A55A5A);
    check("f_err", 32'(err0), 32'd0);
    check("f_mis", 32'(mis0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
